instruction_fetcher: RTL

Per-core instruction fetch stage sitting directly downstream of the program counter. Each time the core scheduler enters FETCH, it reads the instruction at `current_pc` from program memory over a valid/ready handshake. It then presents the latched instruction to the decoder. An optional small direct-mapped instruction cache serves repeated PCs (loops, branch targets) without a memory transaction.

---
 rtl/gpu_pkg.sv | 21 ++
 rtl/fetch_icache.sv | 57 +++++
 rtl/instruction_fetcher.sv | 109 ++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared encodings for the core scheduler and the instruction fetch stage.
package gpu_pkg;

  typedef enum logic [2:0] {
    CoreIdle    = 3'b000,
    CoreFetch   = 3'b001,
    CoreDecode  = 3'b010,
    CoreRequest = 3'b011,
    CoreWait    = 3'b100,
    CoreExecute = 3'b101,
    CoreUpdate  = 3'b110,
    CoreDone    = 3'b111
  } core_state_e;

  typedef enum logic [2:0] {
    FetchIdle     = 3'b000,
    FetchFetching = 3'b001,
    FetchFetched  = 3'b010
  } fetcher_state_e;

endpackage

// File: rtl/fetch_icache.sv
// Direct-mapped instruction cache: combinational lookup, registered fill,
// valid bits cleared on synchronous reset.
module fetch_icache #(
  parameter int unsigned AddrBits = 8,
  parameter int unsigned DataBits = 16,
  parameter int unsigned Lines    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AddrBits-1:0] lookup_addr,
  output logic                hit,
  output logic [DataBits-1:0] hit_data,
  input  logic                fill_en,
  input  logic [AddrBits-1:0] fill_addr,
  input  logic [DataBits-1:0] fill_data
);

  localparam int unsigned IdxBits = $clog2(Lines);
  localparam int unsigned TagBits = AddrBits - IdxBits;

  logic [Lines-1:0]    valid_q, valid_d;
  logic [TagBits-1:0]  tag_q  [Lines];
  logic [TagBits-1:0]  tag_d  [Lines];
  logic [DataBits-1:0] data_q [Lines];
  logic [DataBits-1:0] data_d [Lines];

  logic [IdxBits-1:0] lookup_idx, fill_idx;

  assign lookup_idx = lookup_addr[IdxBits-1:0];
  assign fill_idx   = fill_addr[IdxBits-1:0];

  assign hit      = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_addr[AddrBits-1:IdxBits]);
  assign hit_data = data_q[lookup_idx];

  // A fill always overwrites the indexed line, evicting whatever was there.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d[fill_idx] = 1'b1;
      tag_d[fill_idx]   = fill_addr[AddrBits-1:IdxBits];
      data_d[fill_idx]  = fill_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/instruction_fetcher.sv
// Instruction fetch stage: valid/ready program-memory read per FETCH, latched
// instruction for decode. Define ICACHE_EN to build the direct-mapped icache.
module instruction_fetcher
  import gpu_pkg::*;
#(
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
  parameter int unsigned PROGRAM_MEM_DATA_BITS = 16,
  parameter int unsigned ICACHE_LINES          = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

  fetcher_state_e                   state_q, state_d;
  logic                             valid_q, valid_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q, instr_d;

  logic                             cache_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] cache_data;
  logic                             fill_en;

  assign fill_en = (state_q == FetchFetching) && mem_read_ready;

`ifdef ICACHE_EN
  fetch_icache #(
    .AddrBits (PROGRAM_MEM_ADDR_BITS),
    .DataBits (PROGRAM_MEM_DATA_BITS),
    .Lines    (ICACHE_LINES)
  ) u_icache (
    .clk         (clk),
    .reset       (reset),
    .lookup_addr (current_pc),
    .hit         (cache_hit),
    .hit_data    (cache_data),
    .fill_en     (fill_en),
    .fill_addr   (addr_q),
    .fill_data   (mem_read_data)
  );
`else
  logic unused_cache_cfg;
  assign unused_cache_cfg = (|ICACHE_LINES) ^ fill_en;
  assign cache_hit        = 1'b0;
  assign cache_data       = '0;
`endif

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    unique case (state_q)
      FetchIdle: begin
        if (core_state == CoreFetch) begin
          if (cache_hit) begin
            instr_d = cache_data;
            state_d = FetchFetched;
          end else begin
            valid_d = 1'b1;
            addr_d  = current_pc;
            state_d = FetchFetching;
          end
        end
      end
      FetchFetching: begin
        // Request stays stable until memory answers.
        if (mem_read_ready) begin
          instr_d = mem_read_data;
          valid_d = 1'b0;
          state_d = FetchFetched;
        end
      end
      FetchFetched: begin
        if (core_state == CoreDecode) begin
          state_d = FetchIdle;
        end
      end
      default: state_d = FetchIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FetchIdle;
      valid_q <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
    end
  end

  assign fetcher_state    = state_q;
  assign mem_read_valid   = valid_q;
  assign mem_read_address = addr_q;
  assign instruction      = instr_q;

endmodule
